// File: rtl/miriscv_rvfi_trace_scheduler_if.sv
// Bundle of the RVFI retire port, the trace word stream and the status
// outputs of the trace scheduler. The master side is the core/sink
// environment; the slave side is the scheduler itself.
interface miriscv_rvfi_trace_scheduler_if;

    // Capture control and RVFI retire record
    logic        enable_i;
    logic        rvfi_valid_i;
    logic [63:0] rvfi_order_i;
    logic [31:0] rvfi_pc_rdata_i;
    logic [31:0] rvfi_insn_i;
    logic [31:0] rvfi_rd_wdata_i;
    logic [31:0] rvfi_mem_addr_i;
    logic [4:0]  rvfi_rd_addr_i;
    logic [3:0]  rvfi_mem_rmask_i;
    logic [3:0]  rvfi_mem_wmask_i;
    logic        rvfi_trap_i;
    logic        rvfi_intr_i;

    // Trace word stream
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;

    // Status back to the core / debug
    logic        stall_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    modport master (
        output enable_i,
        output rvfi_valid_i,
        output rvfi_order_i,
        output rvfi_pc_rdata_i,
        output rvfi_insn_i,
        output rvfi_rd_wdata_i,
        output rvfi_mem_addr_i,
        output rvfi_rd_addr_i,
        output rvfi_mem_rmask_i,
        output rvfi_mem_wmask_i,
        output rvfi_trap_i,
        output rvfi_intr_i,
        output trace_ready_i,
        input  trace_valid_o,
        input  trace_data_o,
        input  trace_last_o,
        input  stall_o,
        input  overflow_o,
        input  drop_cnt_o
    );

    modport slave (
        input  enable_i,
        input  rvfi_valid_i,
        input  rvfi_order_i,
        input  rvfi_pc_rdata_i,
        input  rvfi_insn_i,
        input  rvfi_rd_wdata_i,
        input  rvfi_mem_addr_i,
        input  rvfi_rd_addr_i,
        input  rvfi_mem_rmask_i,
        input  rvfi_mem_wmask_i,
        input  rvfi_trap_i,
        input  rvfi_intr_i,
        input  trace_ready_i,
        output trace_valid_o,
        output trace_data_o,
        output trace_last_o,
        output stall_o,
        output overflow_o,
        output drop_cnt_o
    );

endinterface

// File: rtl/miriscv_rvfi_trace_scheduler.sv
// RVFI trace scheduler: captures retired-instruction records into a small
// FIFO and serializes the head record as 4 or 5 32-bit trace words over a
// valid/ready stream. Records that find the FIFO full are dropped and
// counted; the core is warned one entry early through stall_o.
module miriscv_rvfi_trace_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    miriscv_rvfi_trace_scheduler_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Control state
    state_t        state;
    logic [2:0]    idx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          overflow;
    logic [15:0]   drop_cnt;

    // Record storage, one slot per FIFO entry (data only, never reset)
    logic [31:0] pc_q    [DEPTH];
    logic [31:0] insn_q  [DEPTH];
    logic [31:0] meta_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [31:0] addr_q  [DEPTH];
    logic        has_mem_q [DEPTH];

    logic        push_req;
    logic        push_ok;
    logic        hs;
    logic        last_word;
    logic        pop;
    logic [31:0] word;
    logic [31:0] meta_in;
    logic        unused_order;

    // Only the low 16 bits of the retirement order are carried in the trace.
    assign unused_order = ^bus.rvfi_order_i[63:16];

    // Packed W2: order, reserved zero, trap, intr, rd, rmask, wmask.
    assign meta_in = {bus.rvfi_order_i[15:0], 1'b0, bus.rvfi_trap_i, bus.rvfi_intr_i,
                      bus.rvfi_rd_addr_i, bus.rvfi_mem_rmask_i, bus.rvfi_mem_wmask_i};

    assign push_req  = bus.rvfi_valid_i && bus.enable_i;
    assign hs        = (state == SEND) && bus.trace_ready_i;
    assign last_word = (idx == 3'd4) || ((idx == 3'd3) && !has_mem_q[rd_ptr]);
    assign pop       = hs && last_word;
    // A full FIFO still accepts a record when the head leaves the same cycle;
    // the freed slot is exactly the one being written (wr_ptr == rd_ptr).
    assign push_ok   = push_req && ((count < DEPTH_C) || pop);

    // Occupancy after this cycle's push/pop; a coincident push and pop cancel.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Control FSM: pointers, occupancy, word index and drop accounting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            count <= count_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    // Leaving IDLE on the push edge gives the 1-cycle latency.
                    if (count_nxt != '0) begin
                        state <= SEND;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (last_word) begin
                            idx <= '0;
                            if (count_nxt == '0) begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Record capture into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            pc_q[wr_ptr]      <= bus.rvfi_pc_rdata_i;
            insn_q[wr_ptr]    <= bus.rvfi_insn_i;
            meta_q[wr_ptr]    <= meta_in;
            wdata_q[wr_ptr]   <= bus.rvfi_rd_wdata_i;
            addr_q[wr_ptr]    <= bus.rvfi_mem_addr_i;
            has_mem_q[wr_ptr] <= (bus.rvfi_mem_rmask_i | bus.rvfi_mem_wmask_i) != 4'h0;
        end
    end

    // Word select for the head record; all inputs are registers, so the
    // word stays stable while the sink withholds ready.
    always_comb begin
        word = 32'h0;
        case (idx)
            3'd0:    word = pc_q[rd_ptr];
            3'd1:    word = insn_q[rd_ptr];
            3'd2:    word = meta_q[rd_ptr];
            3'd3:    word = wdata_q[rd_ptr];
            3'd4:    word = addr_q[rd_ptr];
            default: word = 32'h0;
        endcase
    end

    assign bus.trace_valid_o = (state == SEND);
    assign bus.trace_data_o  = (state == SEND) ? word : 32'h0;
    assign bus.trace_last_o  = (state == SEND) && last_word;
    assign bus.stall_o       = (count >= STALL_C);
    assign bus.overflow_o    = overflow;
    assign bus.drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_miriscv_rvfi_trace_scheduler.sv
// Directed bench for the RVFI trace scheduler (DEPTH = 4).
module tb_miriscv_rvfi_trace_scheduler;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    miriscv_rvfi_trace_scheduler_if bus_if ();

    miriscv_rvfi_trace_scheduler #(.DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one retire for a single edge, then withdraw it.
    task automatic retire(input logic [15:0] ord, input logic [31:0] pc, input logic [31:0] insn,
                          input logic [4:0] rd, input logic [31:0] wd, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] ma);
        bus_if.rvfi_order_i     = {48'h0, ord};
        bus_if.rvfi_pc_rdata_i  = pc;
        bus_if.rvfi_insn_i      = insn;
        bus_if.rvfi_rd_addr_i   = rd;
        bus_if.rvfi_rd_wdata_i  = wd;
        bus_if.rvfi_mem_rmask_i = rm;
        bus_if.rvfi_mem_wmask_i = wm;
        bus_if.rvfi_mem_addr_i  = ma;
        bus_if.rvfi_valid_i     = 1'b1;
        tick();
        bus_if.rvfi_valid_i     = 1'b0;
    endtask

    // Check the current word, then advance one edge.
    task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
        chk({tag, "_valid"}, 32'(bus_if.trace_valid_o), 32'd1);
        chk({tag, "_data"}, bus_if.trace_data_o, d);
        chk({tag, "_last"}, 32'(bus_if.trace_last_o), 32'(l));
        tick();
    endtask

    function automatic logic [31:0] alu_pc(input int i);
        return 32'h0000_0100 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] alu_insn(input int i);
        return 32'h0000_0013 | (32'(i) << 7);
    endfunction

    function automatic logic [31:0] alu_wd(input int i);
        return 32'(3 * i + 1);
    endfunction

    // W2 of an ALU record with order i and rd = i (no trap/intr, no masks).
    function automatic logic [31:0] alu_meta(input int i);
        return (32'(i) << 16) | (32'(i) << 8);
    endfunction

    task automatic push_alu(input int i);
        retire(16'(i), alu_pc(i), alu_insn(i), 5'(i), alu_wd(i), 4'h0, 4'h0, 32'h0);
    endtask

    // Drain one 4-word ALU record with ready held high.
    task automatic drain_alu(input string tag, input int i);
        expect_word({tag, "_w0"}, alu_pc(i), 1'b0);
        expect_word({tag, "_w1"}, alu_insn(i), 1'b0);
        expect_word({tag, "_w2"}, alu_meta(i), 1'b0);
        expect_word({tag, "_w3"}, alu_wd(i), 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus_if.trace_valid_o), 32'd0);
        chk({tag, "_last"}, 32'(bus_if.trace_last_o), 32'd0);
        chk({tag, "_data"}, bus_if.trace_data_o, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus_if.enable_i         = 1'b1;
        bus_if.rvfi_valid_i     = 1'b0;
        bus_if.rvfi_order_i     = '0;
        bus_if.rvfi_pc_rdata_i  = '0;
        bus_if.rvfi_insn_i      = '0;
        bus_if.rvfi_rd_wdata_i  = '0;
        bus_if.rvfi_mem_addr_i  = '0;
        bus_if.rvfi_rd_addr_i   = '0;
        bus_if.rvfi_mem_rmask_i = '0;
        bus_if.rvfi_mem_wmask_i = '0;
        bus_if.rvfi_trap_i      = 1'b0;
        bus_if.rvfi_intr_i      = 1'b0;
        bus_if.trace_ready_i    = 1'b1;

        // Reset state
        tick();
        tick();
        chk_idle("rst");
        chk("rst_stall", 32'(bus_if.stall_o), 32'd0);
        chk("rst_ovf", 32'(bus_if.overflow_o), 32'd0);
        chk("rst_drop", 32'(bus_if.drop_cnt_o), 32'd0);
        rst = 1'b0;
        tick();
        chk_idle("rst_rel");

        // Single ALU retire, ready high: 4 words, valid one cycle after push
        retire(16'd0, 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h5, 4'h0, 4'h0, 32'h0);
        expect_word("alu_w0", 32'h8000_0000, 1'b0);
        expect_word("alu_w1", 32'h0050_0093, 1'b0);
        expect_word("alu_w2", 32'h0000_0100, 1'b0);
        expect_word("alu_w3", 32'h0000_0005, 1'b1);
        chk_idle("alu_end");

        // Store retire: memory mask present, so a fifth word carries the address
        retire(16'd1, 32'h8000_0004, 32'h0011_2023, 5'd0, 32'h0, 4'h0, 4'hF, 32'h0000_1000);
        expect_word("st_w0", 32'h8000_0004, 1'b0);
        expect_word("st_w1", 32'h0011_2023, 1'b0);
        expect_word("st_w2", 32'h0001_000F, 1'b0);
        expect_word("st_w3", 32'h0000_0000, 1'b0);
        expect_word("st_w4", 32'h0000_1000, 1'b1);
        chk_idle("st_end");

        // Back-pressure: W0 held for 10 cycles, then the sequence resumes
        bus_if.trace_ready_i = 1'b0;
        retire(16'd2, 32'h8000_0008, 32'h00A0_0113, 5'd2, 32'hA, 4'h0, 4'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", 32'(bus_if.trace_valid_o), 32'd1);
            chk("hold_data", bus_if.trace_data_o, 32'h8000_0008);
            chk("hold_last", 32'(bus_if.trace_last_o), 32'd0);
            tick();
        end
        bus_if.trace_ready_i = 1'b1;
        expect_word("bp_w0", 32'h8000_0008, 1'b0);
        expect_word("bp_w1", 32'h00A0_0113, 1'b0);
        expect_word("bp_w2", 32'h0002_0200, 1'b0);
        expect_word("bp_w3", 32'h0000_000A, 1'b1);
        chk_idle("bp_end");

        // Capture disabled: retire is ignored, nothing dropped
        bus_if.enable_i = 1'b0;
        retire(16'd3, 32'h8000_000C, 32'h0000_0013, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0);
        bus_if.enable_i = 1'b1;
        tick();
        chk_idle("dis");
        chk("dis_drop", 32'(bus_if.drop_cnt_o), 32'd0);

        // Overflow: 6 retires into a 4-deep FIFO with the sink stalled
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.trace_ready_i = 1'b0;
        push_alu(0);
        push_alu(1);
        chk("ovf_stall2", 32'(bus_if.stall_o), 32'd0);
        push_alu(2);
        chk("ovf_stall3", 32'(bus_if.stall_o), 32'd1);
        chk("ovf_none3", 32'(bus_if.overflow_o), 32'd0);
        push_alu(3);
        chk("ovf_drop4", 32'(bus_if.drop_cnt_o), 32'd0);
        push_alu(4);
        push_alu(5);
        chk("ovf_flag", 32'(bus_if.overflow_o), 32'd1);
        chk("ovf_drop", 32'(bus_if.drop_cnt_o), 32'd2);
        chk("ovf_stall", 32'(bus_if.stall_o), 32'd1);
        bus_if.trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drain_alu("ovf_rec", i);
        end
        chk_idle("ovf_end");
        chk("ovf_sticky", 32'(bus_if.overflow_o), 32'd1);
        chk("ovf_drop_end", 32'(bus_if.drop_cnt_o), 32'd2);
        chk("ovf_stall_end", 32'(bus_if.stall_o), 32'd0);

        // Full FIFO, push on the same edge as the head's last-word handshake
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("full_rst_drop", 32'(bus_if.drop_cnt_o), 32'd0);
        chk("full_rst_ovf", 32'(bus_if.overflow_o), 32'd0);
        bus_if.trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_alu(i);
        end
        bus_if.trace_ready_i = 1'b1;
        expect_word("full_w0", alu_pc(0), 1'b0);
        expect_word("full_w1", alu_insn(0), 1'b0);
        expect_word("full_w2", alu_meta(0), 1'b0);
        chk("full_w3_last", 32'(bus_if.trace_last_o), 32'd1);
        chk("full_w3_data", bus_if.trace_data_o, alu_wd(0));
        push_alu(4);
        chk("full_drop", 32'(bus_if.drop_cnt_o), 32'd0);
        chk("full_ovf", 32'(bus_if.overflow_o), 32'd0);
        chk("full_stall", 32'(bus_if.stall_o), 32'd1);
        for (int i = 1; i < 5; i++) begin
            drain_alu("full_rec", i);
        end
        chk_idle("full_end");

        // Reset mid-record (during W2) with two records buffered behind it
        bus_if.trace_ready_i = 1'b0;
        push_alu(0);
        push_alu(1);
        push_alu(2);
        bus_if.trace_ready_i = 1'b1;
        expect_word("mid_w0", alu_pc(0), 1'b0);
        expect_word("mid_w1", alu_insn(0), 1'b0);
        chk("mid_w2", bus_if.trace_data_o, alu_meta(0));
        rst = 1'b1;
        tick();
        chk_idle("mid_rst");
        chk("mid_stall", 32'(bus_if.stall_o), 32'd0);
        chk("mid_drop", 32'(bus_if.drop_cnt_o), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk_idle("mid_after");
        push_alu(7);
        drain_alu("mid_new", 7);
        chk_idle("mid_new_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
